fp_exc_issue: RTL and testbench

//  Upstream issue stage for exceptionChecker: accepts an FP operand pair (A,B) via valid/ready,

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fp_exc_issue_if.sv | 42 ++++
 rtl/fp_exc_qualify.sv | 23 ++
 rtl/fp_exc_issue.sv | 170 +++++++++++++++++
 tb/tb_fp_exc_issue.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP exception codes and issue-stage state encoding
// Contents:
//   EXC_NONE / EXC_INF / EXC_NAN : checker exception codes
//   IssueState                   : issue FSM states
package fpu_pkg;

    localparam logic [2:0] EXC_NONE = 3'b000;
    localparam logic [2:0] EXC_INF  = 3'b011;
    localparam logic [2:0] EXC_NAN  = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        REQ_A,
        GAP_A,
        REQ_B,
        GAP_B,
        DONE
    } IssueState;

endpackage

// File: rtl/fp_exc_issue_if.sv
// rtl/fp_exc_issue_if.sv - bus bundle between the FP exception issue stage and its neighbours
// Signals:
//   in_a/in_b/in_valid/in_ready      : operand pair input handshake
//   Data/Data_valid/ACK/Exc          : serial link to the exception checker
//   exc_a/exc_b/out_valid/out_ready  : qualified result handshake to the FPU datapath
//   sticky_inf/sticky_nan/clr_sticky : sticky exception flags and their clear
//   timeout                          : ACK timeout pulse
// Modports:
//   master : the issue stage
//   slave  : the surrounding environment (source, checker and consumer)
interface fp_exc_issue_if;

    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Data;
    logic        Data_valid;
    logic        ACK;
    logic [2:0]  Exc;
    logic [2:0]  exc_a;
    logic [2:0]  exc_b;
    logic        out_valid;
    logic        out_ready;
    logic        sticky_inf;
    logic        sticky_nan;
    logic        clr_sticky;
    logic        timeout;

    modport master (
        input  in_a, in_b, in_valid, ACK, Exc, out_ready, clr_sticky,
        output in_ready, Data, Data_valid, exc_a, exc_b, out_valid,
               sticky_inf, sticky_nan, timeout
    );

    modport slave (
        output in_a, in_b, in_valid, ACK, Exc, out_ready, clr_sticky,
        input  in_ready, Data, Data_valid, exc_a, exc_b, out_valid,
               sticky_inf, sticky_nan, timeout
    );

endinterface

// File: rtl/fp_exc_qualify.sv
// rtl/fp_exc_qualify.sv - masks checker exception codes that do not match the operand
// Ports:
//   exp_i  in  8  biased exponent of the operand being checked
//   exc_i  in  3  raw code returned by the checker
//   code_o out 3  qualified code (INF/NaN only for an all-ones exponent, else NONE)
module fp_exc_qualify
    import fpu_pkg::*;
(
    input  logic [7:0] exp_i,
    input  logic [2:0] exc_i,
    output logic [2:0] code_o
);

    // A finite operand can never be INF/NaN, so anything the checker reports for
    // it is stale and is dropped; unknown codes are dropped for every operand.
    always_comb begin
        code_o = EXC_NONE;
        if (exp_i == 8'hFF && (exc_i == EXC_INF || exc_i == EXC_NAN)) begin
            code_o = exc_i;
        end
    end

endmodule

// File: rtl/fp_exc_issue.sv
// rtl/fp_exc_issue.sv - issues an FP operand pair to the exception checker and returns qualified codes
// Accepts one (A,B) pair, sends A then B to the checker with a recovery gap after
// each ACK, and presents exc_a/exc_b plus sticky INF/NaN flags until consumed.
// Optional feature macro: FPU_ISSUE_TIMEOUT_EN (ACK timeout; forces NaN and pulses timeout).
// Parameters:
//   GAP_CYCLES      idle cycles with Data_valid low after each ACK (>=1)
//   TIMEOUT_CYCLES  REQ cycles without ACK before abort (only with FPU_ISSUE_TIMEOUT_EN)
// Ports:
//   CLK  in  clock
//   RST  in  synchronous reset, active-high
//   bus  fp_exc_issue_if.master (operand input, checker link, result output, stickies)
module fp_exc_issue
    import fpu_pkg::*;
#(
    parameter int GAP_CYCLES = 1
`ifdef FPU_ISSUE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 15
`endif
) (
    input logic           CLK,
    input logic           RST,
    fp_exc_issue_if.master bus
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    IssueState      state_q;
    logic [31:0]    b_q;
    logic [31:0]    data_q;
    logic           data_valid_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [2:0]     exc_a_q;
    logic [2:0]     exc_b_q;
    logic           sticky_inf_q;
    logic           sticky_nan_q;
    logic [GW-1:0]  gap_cnt_q;
    logic [2:0]     code_d;
    IssueState      gap_next_d;

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0]  wait_cnt_q;
    logic           timeout_q;
    logic           wait_expired;

    assign wait_expired = (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign bus.timeout  = timeout_q;
`else
    assign bus.timeout  = 1'b0;
`endif

    // data_q always holds the operand currently on the checker link, so a single
    // qualifier serves both the A and B requests.
    fp_exc_qualify u_qualify (
        .exp_i  (data_q[30:23]),
        .exc_i  (bus.Exc),
        .code_o (code_d)
    );

    assign gap_next_d = (state_q == REQ_A) ? GAP_A : GAP_B;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            b_q          <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            exc_a_q      <= EXC_NONE;
            exc_b_q      <= EXC_NONE;
            sticky_inf_q <= 1'b0;
            sticky_nan_q <= 1'b0;
            gap_cnt_q    <= '0;
`ifdef FPU_ISSUE_TIMEOUT_EN
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
`ifdef FPU_ISSUE_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            // Clear first so that a capture later in this block overrides it.
            if (bus.clr_sticky) begin
                sticky_inf_q <= 1'b0;
                sticky_nan_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_q       <= bus.in_a;
                        b_q          <= bus.in_b;
                        data_valid_q <= 1'b1;
                        in_ready_q   <= 1'b0;
                        state_q      <= REQ_A;
`ifdef FPU_ISSUE_TIMEOUT_EN
                        wait_cnt_q   <= '0;
`endif
                    end
                end

                REQ_A, REQ_B: begin
                    if (bus.ACK) begin
                        if (state_q == REQ_A) exc_a_q <= code_d;
                        else                  exc_b_q <= code_d;
                        if (code_d == EXC_INF) sticky_inf_q <= 1'b1;
                        if (code_d == EXC_NAN) sticky_nan_q <= 1'b1;
                        data_valid_q <= 1'b0;
                        gap_cnt_q    <= '0;
                        state_q      <= gap_next_d;
                    end
`ifdef FPU_ISSUE_TIMEOUT_EN
                    else if (wait_expired) begin
                        if (state_q == REQ_A) exc_a_q <= EXC_NAN;
                        else                  exc_b_q <= EXC_NAN;
                        sticky_nan_q <= 1'b1;
                        timeout_q    <= 1'b1;
                        data_valid_q <= 1'b0;
                        gap_cnt_q    <= '0;
                        state_q      <= gap_next_d;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end

                GAP_A, GAP_B: begin
                    if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                        if (state_q == GAP_A) begin
                            data_q       <= b_q;
                            data_valid_q <= 1'b1;
                            state_q      <= REQ_B;
`ifdef FPU_ISSUE_TIMEOUT_EN
                            wait_cnt_q   <= '0;
`endif
                        end else begin
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.Data       = data_q;
    assign bus.Data_valid = data_valid_q;
    assign bus.exc_a      = exc_a_q;
    assign bus.exc_b      = exc_b_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.sticky_inf = sticky_inf_q;
    assign bus.sticky_nan = sticky_nan_q;

endmodule

// File: tb/tb_fp_exc_issue.sv
// tb/tb_fp_exc_issue.sv - scoreboard bench for fp_exc_issue
module tb_fp_exc_issue;

    localparam int GAP = 1;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic       inf;
        logic       nan;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   acc_cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    fp_exc_issue_if bus ();

    fp_exc_issue dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dv();
        int n = 0;
        while (!bus.Data_valid && n < 50) begin
            tick();
            n++;
        end
        if (!bus.Data_valid) bound_fail("wait_data_valid");
    endtask

    task automatic wait_out();
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!bus.out_valid) bound_fail("wait_out_valid");
    endtask

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready) bound_fail("wait_in_ready");
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        acc_cyc      = cyc;
    endtask

    // Acts as the checker for one request: ACK after 'delay' extra REQ cycles.
    task automatic serve(input logic [31:0] op, input logic [2:0] code, input int delay, input bit clr);
        wait_dv();
        bus.in_valid = 1'b0;
        check("data_operand", bus.Data, op);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("data_valid_held", {31'd0, bus.Data_valid}, 32'd1);
        end
        bus.ACK        = 1'b1;
        bus.Exc        = code;
        bus.clr_sticky = clr;
        tick();
        bus.ACK        = 1'b0;
        bus.Exc        = 3'b000;
        bus.clr_sticky = 1'b0;
    endtask

    // Result monitor: pops one expectation per output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    bound_fail("unexpected_output");
                end else begin
                    e = sb.pop_front();
                    check("exc_a", {29'd0, bus.exc_a}, {29'd0, e.a});
                    check("exc_b", {29'd0, bus.exc_b}, {29'd0, e.b});
                    check("sticky_inf", {31'd0, bus.sticky_inf}, {31'd0, e.inf});
                    check("sticky_nan", {31'd0, bus.sticky_nan}, {31'd0, e.nan});
                end
            end
        end
    end

    // Data_valid must stay low at least GAP cycles between requests.
    initial begin
        int   lo;
        logic prev;
        lo   = 100;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                lo   = 100;
                prev = 1'b0;
            end else begin
                if (bus.Data_valid && !prev) begin
                    n_checks++;
                    if (lo < GAP) begin
                        n_fail++;
                        $display("FAIL dv_gap: got %0d idle cycles required %0d", lo, GAP);
                    end
                end
                lo   = bus.Data_valid ? 0 : lo + 1;
                prev = bus.Data_valid;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        cyc            = 0;
        rst            = 1'b1;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_valid   = 1'b0;
        bus.ACK        = 1'b0;
        bus.Exc        = 3'b000;
        bus.out_ready  = 1'b1;
        bus.clr_sticky = 1'b0;
        repeat (3) tick();

        check("rst_in_ready",   {31'd0, bus.in_ready},   32'd1);
        check("rst_data",       bus.Data,                32'd0);
        check("rst_data_valid", {31'd0, bus.Data_valid}, 32'd0);
        check("rst_exc_a",      {29'd0, bus.exc_a},      32'd0);
        check("rst_exc_b",      {29'd0, bus.exc_b},      32'd0);
        check("rst_out_valid",  {31'd0, bus.out_valid},  32'd0);
        check("rst_sticky_inf", {31'd0, bus.sticky_inf}, 32'd0);
        check("rst_sticky_nan", {31'd0, bus.sticky_nan}, 32'd0);
        check("rst_timeout",    {31'd0, bus.timeout},    32'd0);
        rst = 1'b0;
        tick();

        // +inf / 1.0, ACK in the request cycle, latency check.
        sb.push_back('{a: 3'b011, b: 3'b000, inf: 1'b1, nan: 1'b0});
        send_pair(32'h7F800000, 32'h3F800000);
        serve(32'h7F800000, 3'b011, 0, 1'b0);
        serve(32'h3F800000, 3'b000, 0, 1'b0);
        wait_out();
        check("latency_out_valid", cyc - acc_cyc, 32'd4);
        tick();

        // qNaN / -inf, ACK after 3 cycles.
        sb.push_back('{a: 3'b100, b: 3'b011, inf: 1'b1, nan: 1'b1});
        send_pair(32'h7FC00000, 32'hFF800000);
        serve(32'h7FC00000, 3'b100, 3, 1'b0);
        serve(32'hFF800000, 3'b011, 3, 1'b0);
        wait_out();
        tick();

        // clr_sticky coincident with an INF capture: INF set wins, NaN cleared.
        sb.push_back('{a: 3'b011, b: 3'b000, inf: 1'b1, nan: 1'b0});
        send_pair(32'hFF800000, 32'h40490FDB);
        serve(32'hFF800000, 3'b011, 0, 1'b1);
        serve(32'h40490FDB, 3'b000, 0, 1'b0);
        wait_out();
        tick();

        bus.clr_sticky = 1'b1;
        tick();
        bus.clr_sticky = 1'b0;
        check("clr_sticky_inf", {31'd0, bus.sticky_inf}, 32'd0);
        check("clr_sticky_nan", {31'd0, bus.sticky_nan}, 32'd0);

        // Finite operands with stale INF code: masked, stickies stay clear.
        sb.push_back('{a: 3'b000, b: 3'b000, inf: 1'b0, nan: 1'b0});
        send_pair(32'h3F800000, 32'hC0000000);
        serve(32'h3F800000, 3'b011, 1, 1'b0);
        serve(32'hC0000000, 3'b011, 1, 1'b0);
        wait_out();
        tick();

        // Back-pressure in DONE; garbage code on NaN masked; ACK outside REQ ignored.
        bus.out_ready = 1'b0;
        sb.push_back('{a: 3'b000, b: 3'b011, inf: 1'b1, nan: 1'b0});
        send_pair(32'h7F800001, 32'h7F800000);
        serve(32'h7F800001, 3'b101, 0, 1'b0);
        serve(32'h7F800000, 3'b011, 0, 1'b0);
        wait_out();
        bus.in_a     = 32'h3F800000;
        bus.in_b     = 32'h3F800000;
        bus.in_valid = 1'b1;
        bus.ACK      = 1'b1;
        bus.Exc      = 3'b100;
        for (int i = 0; i < 4; i++) begin
            check("stall_out_valid",  {31'd0, bus.out_valid},  32'd1);
            check("stall_exc_a",      {29'd0, bus.exc_a},      32'd0);
            check("stall_exc_b",      {29'd0, bus.exc_b},      32'd3);
            check("stall_in_ready",   {31'd0, bus.in_ready},   32'd0);
            check("stall_data_valid", {31'd0, bus.Data_valid}, 32'd0);
            check("stall_sticky_nan", {31'd0, bus.sticky_nan}, 32'd0);
            tick();
        end
        bus.ACK = 1'b0;
        bus.Exc = 3'b000;
        sb.push_back('{a: 3'b000, b: 3'b000, inf: 1'b1, nan: 1'b0});
        bus.out_ready = 1'b1;
        serve(32'h3F800000, 3'b000, 0, 1'b0);
        serve(32'h3F800000, 3'b000, 0, 1'b0);
        wait_out();
        tick();

        // Reset while waiting in REQ_B.
        send_pair(32'h3F800000, 32'h7F800000);
        serve(32'h3F800000, 3'b000, 0, 1'b0);
        wait_dv();
        rst = 1'b1;
        tick();
        check("midrst_data_valid", {31'd0, bus.Data_valid}, 32'd0);
        check("midrst_out_valid",  {31'd0, bus.out_valid},  32'd0);
        check("midrst_in_ready",   {31'd0, bus.in_ready},   32'd1);
        check("midrst_sticky_inf", {31'd0, bus.sticky_inf}, 32'd0);
        rst = 1'b0;
        tick();

        // Recovery after reset.
        sb.push_back('{a: 3'b100, b: 3'b000, inf: 1'b0, nan: 1'b1});
        send_pair(32'h7FC00000, 32'h00000000);
        serve(32'h7FC00000, 3'b100, 2, 1'b0);
        serve(32'h00000000, 3'b000, 0, 1'b0);
        wait_out();
        tick();

`ifdef FPU_ISSUE_TIMEOUT_EN
        // No ACK for A: abort after 15 REQ cycles with forced NaN.
        bus.clr_sticky = 1'b1;
        tick();
        bus.clr_sticky = 1'b0;
        sb.push_back('{a: 3'b100, b: 3'b000, inf: 1'b0, nan: 1'b1});
        send_pair(32'h3F800000, 32'h3F800000);
        begin
            int n = 0;
            while (!bus.timeout && n < 40) begin
                tick();
                n++;
            end
            if (!bus.timeout) bound_fail("wait_timeout");
            check("timeout_latency", cyc - acc_cyc, 32'd15);
            check("timeout_data_valid", {31'd0, bus.Data_valid}, 32'd0);
            tick();
            check("timeout_pulse_width", {31'd0, bus.timeout}, 32'd0);
        end
        serve(32'h3F800000, 3'b000, 0, 1'b0);
        wait_out();
        tick();
`else
        check("timeout_tied_low", {31'd0, bus.timeout}, 32'd0);
`endif

        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
